// File: rtl/mac_dot_sequencer_if.sv
// Bundles the layer-controller command port, the operand buffer read port and
// the result valid/ready port of the dot-product sequencer.
interface mac_dot_sequencer_if #(
    parameter int LA    = 8,
    parameter int LB    = 8,
    parameter int LACC  = 24,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             sg;
    logic             busy;
    logic             rd_en;
    logic [LEN_W-1:0] a_addr;
    logic [LEN_W-1:0] b_addr;
    logic [LA-1:0]    a_data;
    logic [LB-1:0]    b_data;
    logic             out_valid;
    logic             out_ready;
    logic [LACC-1:0]  y;

    // Controller, buffers and result consumer side.
    modport master (
        output start, len, sg, a_data, b_data, out_ready,
        input  busy, rd_en, a_addr, b_addr, out_valid, y
    );

    // Sequencer side.
    modport slave (
        input  start, len, sg, a_data, b_data, out_ready,
        output busy, rd_en, a_addr, b_addr, out_valid, y
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Walks two synchronous-read operand buffers in lockstep, accumulating one
// signed or unsigned product per cycle, and hands the sum out on valid/ready.
module mac_dot_sequencer #(
    parameter int LA    = 8,
    parameter int LB    = 8,
    parameter int LACC  = 24,
    parameter int LEN_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    mac_dot_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t           state;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] last_idx;
    logic             sg_q;
    logic             busy_q;
    logic             rd_en_q;
    logic             out_valid_q;
    logic             pipe;
    logic [LACC-1:0]  acc;
    logic [LA+LB-1:0] a_wide;
    logic [LA+LB-1:0] b_wide;
    logic [LA+LB-1:0] prod;
    logic [LACC-1:0]  prod_ext;

    // Widening operands to the product width first makes the low LA+LB bits
    // of one unsigned multiply correct for both signed and unsigned modes.
    assign a_wide   = sg_q ? (LA+LB)'($signed(bus.a_data)) : (LA+LB)'(bus.a_data);
    assign b_wide   = sg_q ? (LA+LB)'($signed(bus.b_data)) : (LA+LB)'(bus.b_data);
    assign prod     = a_wide * b_wide;
    assign prod_ext = sg_q ? LACC'($signed(prod)) : LACC'(prod);
    assign last_idx = len_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            len_q       <= '0;
            sg_q        <= 1'b0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            pipe        <= 1'b0;
            acc         <= '0;
        end else begin
            // Read data lags the strobe by one cycle, so the accumulate does too.
            pipe <= rd_en_q;
            if (pipe) begin
                acc <= acc + prod_ext;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            len_q   <= bus.len;
                            sg_q    <= bus.sg;
                            idx     <= '0;
                            rd_en_q <= 1'b1;
                            state   <= RUN;
                        end else begin
                            out_valid_q <= 1'b1;
                            state       <= OUT;
                        end
                    end
                end
                RUN: begin
                    if (idx == last_idx) begin
                        rd_en_q <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.a_addr    = idx;
    assign bus.b_addr    = idx;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = acc;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: a vector table, hand-built
// corner sequences and random runs checked against an arithmetic dot-product model.
module tb_mac_dot_sequencer;
    localparam int LA    = 8;
    localparam int LB    = 8;
    localparam int LACC  = 24;
    localparam int LEN_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mac_dot_sequencer_if #(.LA(LA), .LB(LB), .LACC(LACC), .LEN_W(LEN_W)) bus ();

    mac_dot_sequencer #(.LA(LA), .LB(LB), .LACC(LACC), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] feat_mem [256];
    logic [7:0] wt_mem   [256];

    // Synchronous-read operand buffers.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_data <= feat_mem[bus.a_addr];
            bus.b_data <= wt_mem[bus.b_addr];
        end
    end

    typedef struct packed {
        logic [7:0]  len;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  hold;
        logic [23:0] y;
    } vec_t;

    vec_t vectors [8];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Plain integer dot product, wrapped to the accumulator width.
    function automatic logic [23:0] refDot(input int n, input bit s);
        longint     sum;
        longint     av;
        longint     bv;
        logic [63:0] raw;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            av = longint'(feat_mem[i]);
            bv = longint'(wt_mem[i]);
            if (s && av > 127) av = av - 256;
            if (s && bv > 127) bv = bv - 256;
            sum = sum + av * bv;
        end
        raw = sum;
        return raw[23:0];
    endfunction

    task automatic applyStimulus(input int n, input bit s, input int hold,
                                 output logic [23:0] y_got, output int lat, output int nrd,
                                 output int last_addr, output bit addr_ok, output bit busy_ok,
                                 output bit hold_ok, output bit idle_ok, output bit timeout);
        y_got     = '0;
        lat       = 0;
        nrd       = 0;
        last_addr = -1;
        addr_ok   = 1'b1;
        busy_ok   = 1'b1;
        hold_ok   = 1'b1;
        idle_ok   = 1'b1;
        timeout   = 1'b1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.len       = 8'(n);
        bus.sg        = s;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 8'($urandom);
        bus.sg    = 1'($urandom);
        for (int c = 1; c <= n + 10; c++) begin
            if (c > 1) @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.rd_en) begin
                if (int'(bus.a_addr) != nrd || int'(bus.b_addr) != nrd) addr_ok = 1'b0;
                last_addr = int'(bus.a_addr);
                nrd++;
            end
            if (bus.out_valid) begin
                lat     = c;
                y_got   = bus.y;
                timeout = 1'b0;
                break;
            end
        end
        if (timeout) return;
        for (int h = 0; h < hold; h++) begin
            bus.start = (h == 2);
            @(negedge clk);
            if (!bus.out_valid || bus.y !== y_got || !bus.busy) hold_ok = 1'b0;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (bus.busy || bus.out_valid) idle_ok = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy || bus.rd_en || bus.out_valid) idle_ok = 1'b0;
        end
    endtask

    task automatic runAndCheck(input string name, input int n, input bit s, input int hold,
                               input logic [23:0] y_exp, output int last_addr);
        logic [23:0] y_got;
        int          lat;
        int          nrd;
        bit          addr_ok, busy_ok, hold_ok, idle_ok, timeout;
        applyStimulus(n, s, hold, y_got, lat, nrd, last_addr, addr_ok, busy_ok, hold_ok, idle_ok, timeout);
        checkOutput({name, " timeout"}, 32'(timeout), 32'd0);
        checkOutput({name, " y"}, 32'(y_got), 32'(y_exp));
        checkOutput({name, " latency"}, 32'(lat), (n == 0) ? 32'd1 : 32'(n + 2));
        checkOutput({name, " reads"}, 32'(nrd), 32'(n));
        checkOutput({name, " addr"}, 32'(addr_ok), 32'd1);
        checkOutput({name, " busy"}, 32'(busy_ok), 32'd1);
        checkOutput({name, " hold"}, 32'(hold_ok), 32'd1);
        checkOutput({name, " idle"}, 32'(idle_ok), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          last_addr;
        int          n;
        bit          s;
        logic [31:0] av;
        logic [31:0] bv;
        logic [23:0] y_exp;

        vectors[0] = '{len: 8'd3, sg: 1'b0, a: 32'h00030201, b: 32'h00060504, hold: 4'd0, y: 24'd32};
        vectors[1] = '{len: 8'd2, sg: 1'b1, a: 32'h000080FF, b: 32'h00007F02, hold: 4'd0, y: 24'hFFC07E};
        vectors[2] = '{len: 8'd2, sg: 1'b0, a: 32'h000080FF, b: 32'h00007F02, hold: 4'd0, y: 24'h00417E};
        vectors[3] = '{len: 8'd0, sg: 1'b0, a: 32'h00000000, b: 32'h00000000, hold: 4'd0, y: 24'h000000};
        vectors[4] = '{len: 8'd1, sg: 1'b1, a: 32'h00000080, b: 32'h00000080, hold: 4'd0, y: 24'h004000};
        vectors[5] = '{len: 8'd4, sg: 1'b1, a: 32'h7F7F7F7F, b: 32'h81818181, hold: 4'd0, y: 24'hFF03FC};
        vectors[6] = '{len: 8'd4, sg: 1'b0, a: 32'h7F7F7F7F, b: 32'h81818181, hold: 4'd0, y: 24'h00FFFC};
        vectors[7] = '{len: 8'd3, sg: 1'b0, a: 32'h00030201, b: 32'h00060504, hold: 4'd5, y: 24'd32};

        bus.start     = 1'b0;
        bus.len       = '0;
        bus.sg        = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            feat_mem[i] = '0;
            wt_mem[i]   = '0;
        end

        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset rd_en", 32'(bus.rd_en), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset y", 32'(bus.y), 32'd0);
        rst_n = 1'b1;

        // Table vectors, including signed/unsigned, zero length and backpressure.
        for (int v = 0; v < 8; v++) begin
            av = vectors[v].a;
            bv = vectors[v].b;
            for (int i = 0; i < 4; i++) begin
                feat_mem[i] = av[8*i +: 8];
                wt_mem[i]   = bv[8*i +: 8];
            end
            runAndCheck($sformatf("vec%0d", v), int'(vectors[v].len), vectors[v].sg,
                        int'(vectors[v].hold), vectors[v].y, last_addr);
        end

        // Asynchronous reset in the middle of a long run.
        for (int i = 0; i < 10; i++) begin
            feat_mem[i] = 8'($urandom_range(1, 255));
            wt_mem[i]   = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        bus.start     = 1'b1;
        bus.len       = 8'd10;
        bus.sg        = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrun rd_en before reset", 32'(bus.rd_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset busy", 32'(bus.busy), 32'd0);
        checkOutput("midrun reset rd_en", 32'(bus.rd_en), 32'd0);
        checkOutput("midrun reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrun reset y", 32'(bus.y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        feat_mem[0] = 8'd1; feat_mem[1] = 8'd2; feat_mem[2] = 8'd3;
        wt_mem[0]   = 8'd4; wt_mem[1]   = 8'd5; wt_mem[2]   = 8'd6;
        runAndCheck("after reset", 3, 1'b0, 0, 24'd32, last_addr);

        // Maximum length, all operands 0xFF.
        for (int i = 0; i < 256; i++) begin
            feat_mem[i] = 8'hFF;
            wt_mem[i]   = 8'hFF;
        end
        runAndCheck("full length", 255, 1'b0, 0, 24'hFD02FF, last_addr);
        checkOutput("full length last addr", 32'(last_addr), 32'd254);

        // Random runs against the reference model.
        for (int k = 0; k < 12; k++) begin
            n = (k == 0) ? 0 : $urandom_range(1, 24);
            s = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                feat_mem[i] = 8'($urandom);
                wt_mem[i]   = 8'($urandom);
            end
            y_exp = refDot(n, s);
            runAndCheck($sformatf("rand%0d", k), n, s, $urandom_range(0, 3), y_exp, last_addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
